pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It decodes the ID-stage instruction's source-register usage from its opcode and checks it against the load in EX to insert load-use bubbles. It also applies redirect flushes from taken branches and jumps, and freezes the whole pipeline while data memory is busy. It keeps saturating performance counters and a sticky memory-hold watchdog.

## Interface
Parameters:
- CNT_W, 32: width of each performance counter.
- HOLD_TIMEOUT, 256: number of consecutive mem_busy cycles that sets hold_timeout; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_inst  in  32  instruction currently in IF/ID.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  a branch resolved taken in EX, or a JAL/JALR is in EX.
- mem_busy  in  1  data memory is not ready; the pipeline must freeze.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- ex_mem_write  out  1  EX/MEM and MEM/WB register enable.
- if_id_flush  out  1  load NOP (0x00000013) into IF/ID.
- id_ex_flush  out  1  load a bubble (all control bits zero) into ID/EX.
- ctrl_state  out  2  registered action taken in the previous cycle (ctrl_state_e).
- stall_count  out  CNT_W  number of load-use bubbles inserted.
- flush_count  out  CNT_W  number of redirect cycles.
- hold_count  out  CNT_W  number of mem_busy cycles.
- hold_timeout  out  1  sticky error flag.

## Operation
- Source-register usage is decoded from id_inst[6:0]:
  - 0110011, 0100011, 1100011: use rs1 and rs2.
  - 0000011, 0010011, 1100111: use rs1 only.
  - 0110111, 1101111, and any other opcode: use no source registers.
- rs1 = id_inst[19:15] and rs2 = id_inst[24:20]. A source equal to x0 never matches.
- lu_hit = id_ex_mem_read && id_ex_rd != 0 && (rs1 is used and equals id_ex_rd, or rs2 is used and equals id_ex_rd) && ctrl_state != LU_STALL.
- Each cycle's action is chosen by priority, highest first:
  1. **HOLD** (mem_busy=1): all four *_write outputs are 0 and both flushes are 0.
  2. **REDIRECT** (ex_redirect=1): all writes are 1, if_id_flush=1, id_ex_flush=1.
  3. **LU_STALL** (lu_hit=1): pc_write=0, if_id_write=0, id_ex_write=1, ex_mem_write=1, id_ex_flush=1.
  4. **RUN** (otherwise): all writes are 1 and both flushes are 0.
- ctrl_state_e encoding: RUN=0, LU_STALL=1, REDIRECT=2, HOLD=3. The chosen action is registered into ctrl_state.
- A redirect that is pending during HOLD is not lost. EX is frozen, so ex_redirect stays asserted and is applied in the first cycle after mem_busy falls.
- Counters increment on a clock edge at the end of a cycle of the matching action: LU_STALL → stall_count, REDIRECT → flush_count, HOLD → hold_count.
- Counters saturate at all-ones and never wrap.
- An internal counter hold_run, saturating at HOLD_TIMEOUT, counts consecutive HOLD cycles and clears on any non-HOLD cycle.
- hold_timeout sets on the edge at which hold_run reaches HOLD_TIMEOUT, and stays set until reset.

## Timing
- The control outputs (pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush) are combinational from the inputs and ctrl_state, with zero latency.
- Counters, ctrl_state and hold_timeout are registered and become visible one cycle after the event.
- Reset values: ctrl_state=RUN, all counters 0, hold_run 0, hold_timeout 0. With reset asserted and inputs idle, the control outputs show the RUN pattern.
- A load-use stall lasts exactly one cycle. The suppression via ctrl_state guarantees no back-to-back stall, even if ID/EX inputs are stale.
- Reset asserted mid-HOLD or mid-stall clears all state asynchronously. The first cycle after reset deasserts is evaluated from the inputs alone.
- If mem_busy and ex_redirect are asserted together, HOLD wins and flush_count does not change.

## Structure
- riscv_pkg holds the opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL, OP_JALR, OP_OPIMM, OP_OP), the ctrl_state_e typedef and NOP_INST.
- Sub-module src_use_decode (input opcode; outputs uses_rs1, uses_rs2) holds the opcode→usage decode, separating it from the FSM and counters.

## Test plan
- id_ex_mem_read=1, id_ex_rd=5, id_inst=0x00728333 (add x6,x5,x7) → one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; next cycle RUN; stall_count 0→1.
- Same load with id_inst=0x12345337 (lui x6) → RUN, no stall. With id_ex_rd=0 and a matching add → no stall.
- Load-use condition plus ex_redirect=1 in the same cycle → if_id_flush=1, id_ex_flush=1, all writes=1; flush_count+1 and stall_count unchanged.
- mem_busy=1 together with ex_redirect=1 for 3 cycles, then mem_busy=0 → 3 HOLD cycles with all writes=0, then one REDIRECT; hold_count=3, flush_count=1.
- HOLD_TIMEOUT=4, mem_busy held for 4 cycles → hold_timeout=1 after the 4th edge and still 1 after mem_busy falls. Asserting reset mid-hold clears every counter and the flag.
- CNT_W=4 with 17 alternating redirects → flush_count saturates at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the hazard controller's action encoding.
package riscv_pkg;

  // Major opcodes (inst[6:0]) that matter for source-register usage.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // addi x0, x0, 0 -- what the IF/ID flush loads.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Action taken by the controller in a cycle, in priority order HOLD > REDIRECT > LU_STALL > RUN.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2,
    HOLD     = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/src_use_decode.sv
// Opcode -> source-register usage decode for the ID-stage instruction.
module src_use_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  // Classify the opcode into rs1+rs2, rs1-only or no-source formats.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_OP, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LOAD, OP_OPIMM, OP_JALR: begin
        uses_rs1 = 1'b1;
      end
      default: ;  // LUI, JAL and unknown opcodes read no registers
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, redirect flush and memory-hold sequencing for the 5-stage pipeline,
// with saturating performance counters and a sticky memory-hold watchdog.
module pipe_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int HOLD_TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_inst,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] hold_count,
  output logic             hold_timeout
);

  localparam int              RUN_W   = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HOLD_TIMEOUT);

  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             lu_hit;
  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  logic [RUN_W-1:0] hold_run_q;

  // Instruction fields not involved in hazard detection.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];

  src_use_decode u_decode (
    .opcode   (id_inst[6:0]),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // A load in EX feeds a used source of the ID instruction; never twice in a row.
  assign lu_hit = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                  ((uses_rs1 && (rs1 == id_ex_rd)) || (uses_rs2 && (rs2 == id_ex_rd))) &&
                  (state_q != LU_STALL);

  // Priority action select and the matching enable/flush pattern.
  always_comb begin
    state_d      = RUN;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (mem_busy) begin
      state_d      = HOLD;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (ex_redirect) begin
      state_d     = REDIRECT;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_hit) begin
      state_d     = LU_STALL;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Register the action taken this cycle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign ctrl_state = state_q;

  // Saturating per-action performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
      hold_count  <= '0;
    end else begin
      if (state_d == LU_STALL && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (state_d == REDIRECT && flush_count != '1) flush_count <= flush_count + 1'b1;
      if (state_d == HOLD     && hold_count  != '1) hold_count  <= hold_count  + 1'b1;
    end
  end

  // Consecutive-hold watchdog; the flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_run_q   <= '0;
      hold_timeout <= 1'b0;
    end else if (state_d == HOLD) begin
      if (hold_run_q != RUN_MAX) hold_run_q <= hold_run_q + 1'b1;
      // This edge brings hold_run to (or keeps it at) the limit.
      if (hold_run_q >= RUN_MAX - 1'b1) hold_timeout <= 1'b1;
    end else begin
      hold_run_q <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then randomized traffic,
// all compared against a cycle-level reference model of the controller's rules.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int HT      = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [31:0] ADD_X6_X5_X7 = 32'h0072_8333;
  localparam logic [31:0] LUI_X6       = 32'h1234_5337;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      id_inst;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rd;
  logic             ex_redirect;
  logic             mem_busy;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic             if_id_flush, id_ex_flush;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_count, flush_count, hold_count;
  logic             hold_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state: previous action (0 run, 1 stall, 2 redirect, 3 hold) and counts.
  int m_prev, m_stall, m_flush, m_hold, m_run;
  bit m_tmo;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .HOLD_TIMEOUT(HT)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_inst        (id_inst),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .ex_redirect    (ex_redirect),
    .mem_busy       (mem_busy),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_write    (id_ex_write),
    .ex_mem_write   (ex_mem_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ctrl_state     (ctrl_state),
    .stall_count    (stall_count),
    .flush_count    (flush_count),
    .hold_count     (hold_count),
    .hold_timeout   (hold_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which source registers an opcode reads (instruction-format table).
  function automatic void model_uses(input logic [6:0] op, output bit u1, output bit u2);
    u1 = 0; u2 = 0;
    if (op == 7'h33 || op == 7'h23 || op == 7'h63) begin u1 = 1; u2 = 1; end
    else if (op == 7'h03 || op == 7'h13 || op == 7'h67) u1 = 1;
  endfunction

  // Action the controller should take for the current inputs and the previous action.
  function automatic int model_action();
    bit u1, u2, hit;
    model_uses(id_inst[6:0], u1, u2);
    hit = id_ex_mem_read && id_ex_rd != 0 &&
          ((u1 && id_inst[19:15] == id_ex_rd) || (u2 && id_inst[24:20] == id_ex_rd));
    if (mem_busy)                 return 3;
    if (ex_redirect)              return 2;
    if (hit && m_prev != 1)       return 1;
    return 0;
  endfunction

  // Expected {pc, if_id, id_ex, ex_mem write, if_id_flush, id_ex_flush} per action.
  function automatic logic [5:0] pattern(input int a);
    case (a)
      1:       return 6'b001101;
      2:       return 6'b111111;
      3:       return 6'b000000;
      default: return 6'b111100;
    endcase
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v >= lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_stall = 0; m_flush = 0; m_hold = 0; m_run = 0; m_tmo = 0;
  endtask

  task automatic model_clock();
    int a;
    a = model_action();
    if (a == 1) m_stall = sat(m_stall + 1, CNT_MAX);
    if (a == 2) m_flush = sat(m_flush + 1, CNT_MAX);
    if (a == 3) m_hold  = sat(m_hold + 1, CNT_MAX);
    m_run = (a == 3) ? sat(m_run + 1, HT) : 0;
    if (m_run == HT) m_tmo = 1;
    m_prev = a;
  endtask

  task automatic compare_all();
    check("ctrl_pattern", {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush},
          pattern(model_action()));
    check("ctrl_state", ctrl_state, m_prev);
    check("stall_count", stall_count, m_stall);
    check("flush_count", flush_count, m_flush);
    check("hold_count", hold_count, m_hold);
    check("hold_timeout", hold_timeout, m_tmo);
  endtask

  // One cycle: called at a falling edge, drives inputs, checks, advances model at the rising edge.
  task automatic step(input logic [31:0] inst, input logic mr, input logic [4:0] rd,
                      input logic redir, input logic busy);
    id_inst = inst; id_ex_mem_read = mr; id_ex_rd = rd; ex_redirect = redir; mem_busy = busy;
    #1;
    compare_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  // Pulse reset asynchronously mid-cycle with inputs left as they are, then go idle.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    id_inst = 32'h0000_0013; id_ex_mem_read = 0; id_ex_rd = 0; ex_redirect = 0; mem_busy = 0;
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    id_inst = 32'h0000_0013; id_ex_mem_read = 0; id_ex_rd = 0; ex_redirect = 0; mem_busy = 0;
    model_reset();
    @(negedge clk);
    #1;
    check("reset_pattern", {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush},
          6'b111100);
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Load-use on add x6,x5,x7: one bubble, then RUN with stale inputs.
    step(ADD_X6_X5_X7, 1, 5, 0, 0);
    check("lu_state", ctrl_state, 1);
    check("lu_stall_cnt", stall_count, 1);
    step(ADD_X6_X5_X7, 1, 5, 0, 0);
    check("lu_no_repeat", ctrl_state, 0);
    check("lu_stall_cnt_kept", stall_count, 1);

    // LUI reads nothing; rd=x0 never matches.
    step(LUI_X6, 1, 6, 0, 0);
    step(ADD_X6_X5_X7, 1, 0, 0, 0);
    check("no_stall_cnt", stall_count, 1);

    // Redirect beats load-use.
    step(ADD_X6_X5_X7, 1, 5, 1, 0);
    check("redir_flush_cnt", flush_count, 1);
    check("redir_stall_cnt", stall_count, 1);

    // Hold with a pending redirect: 3 hold cycles, then the redirect.
    do_reset();
    for (int i = 0; i < 3; i++) step(32'h0000_0013, 0, 0, 1, 1);
    step(32'h0000_0013, 0, 0, 1, 0);
    check("hold_cnt3", hold_count, 3);
    check("hold_flush1", flush_count, 1);
    check("hold_no_tmo", hold_timeout, 0);

    // Watchdog: 4 consecutive hold cycles set the sticky flag.
    do_reset();
    for (int i = 0; i < HT; i++) step(32'h0000_0013, 0, 0, 0, 1);
    check("tmo_set", hold_timeout, 1);
    step(32'h0000_0013, 0, 0, 0, 0);
    check("tmo_sticky", hold_timeout, 1);
    step(32'h0000_0013, 0, 0, 0, 1);
    do_reset();
    check("tmo_cleared", hold_timeout, 0);
    check("hold_cleared", hold_count, 0);

    // Counter saturation: 17 redirects interleaved with RUN cycles.
    for (int i = 0; i < 17; i++) begin
      step(32'h0000_0013, 0, 0, 1, 0);
      step(32'h0000_0013, 0, 0, 0, 0);
    end
    check("flush_sat", flush_count, CNT_MAX);

    // Randomized traffic with bursty mem_busy and occasional asynchronous resets.
    do_reset();
    begin
      logic [6:0]  ops [9];
      logic        busy = 0;
      ops = '{7'h33, 7'h23, 7'h63, 7'h03, 7'h13, 7'h67, 7'h37, 7'h6f, 7'h0b};
      for (int i = 0; i < 3000; i++) begin
        logic [31:0] inst;
        inst = $urandom;
        inst[6:0]   = ops[$urandom_range(8)];
        inst[19:15] = 5'($urandom_range(7));
        inst[24:20] = 5'($urandom_range(7));
        if ($urandom_range(9) < 2) busy = ~busy;
        step(inst, ($urandom_range(9) < 6), 5'($urandom_range(7)), ($urandom_range(9) < 2), busy);
        if ($urandom_range(399) == 0) do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
